rect_fill_engine: RTL and testbench

- Solid-rectangle fill engine for the 1-bit-per-pixel 320x200 framebuffer.
- Sits directly downstream of the EPP host register interface. It consumes that interface's X1/Y1/X2/Y2, fill_value and start_fill pulse.
- Issues byte-wide masked writes to the framebuffer memory port under a valid/ready handshake, one row at a time.

---
 rtl/gfx_pkg.sv | 24 ++
 rtl/edge_mask_gen.sv | 21 ++
 rtl/rect_fill_engine.sv | 162 ++++++++++++++++
 tb/tb_rect_fill_engine.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared graphics constants, coordinate types and fill-engine state encoding.
// Reused by the fill engine, blit engine and display scanout.
package gfx_pkg;

  localparam int H_RES         = 320;
  localparam int V_RES         = 200;
  localparam int BYTES_PER_ROW = H_RES / 8;
  localparam int ADDR_W        = 13;

  typedef logic [8:0] x_t;
  typedef logic [7:0] y_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WRITE,
    DONE
  } fill_state_e;

  localparam x_t X_MAX = x_t'(H_RES - 1);
  localparam y_t Y_MAX = y_t'(V_RES - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(BYTES_PER_ROW);

endpackage

// File: rtl/edge_mask_gen.sv
// Per-byte pixel enable for a horizontal span; LSB is the leftmost pixel.
// Edge bytes trim pixels outside [xl, xr]; interior bytes enable all eight.
module edge_mask_gen (
  input  logic [2:0] xl_i,
  input  logic [2:0] xr_i,
  input  logic       is_left_i,
  input  logic       is_right_i,
  output logic [7:0] mask_o
);

  always_comb begin
    mask_o = 8'hFF;
    if (is_left_i) begin
      mask_o = mask_o & (8'hFF << xl_i);
    end
    if (is_right_i) begin
      mask_o = mask_o & (8'hFF >> (3'd7 - xr_i));
    end
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Solid-rectangle fill for the 1bpp 320x200 framebuffer: walks the clipped
// rectangle row by row, issuing one masked byte write per accepted handshake.
module rect_fill_engine
  import gfx_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_fill_i,
  input  logic              fill_value_i,
  input  x_t                x1_i,
  input  y_t                y1_i,
  input  x_t                x2_i,
  input  y_t                y2_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fb_we_o,
  output logic [ADDR_W-1:0] fb_addr_o,
  output logic [7:0]        fb_data_o,
  output logic [7:0]        fb_mask_o,
  input  logic              fb_ready_i
);

  fill_state_e       state_q, state_d;
  x_t                x1_q, x1_d, x2_q, x2_d;
  y_t                y1_q, y1_d, y2_q, y2_d;
  logic              fill_q, fill_d;
  logic [2:0]        xlLo_q, xlLo_d, xrLo_q, xrLo_d;
  logic [5:0]        bl_q, bl_d, br_q, br_d, col_q, col_d;
  y_t                yb_q, yb_d, row_q, row_d;
  logic [ADDR_W-1:0] rowBase_q, rowBase_d;

  x_t                xlMin, xrMax, xlClip, xrClip;
  y_t                ytMin, ybMax, ytClip, ybClip;
  logic [ADDR_W-1:0] ytWide, rowBaseInit, wrAddr;
  logic [7:0]        wrMask;
  logic              inWrite;

  assign xlMin  = (x1_q < x2_q) ? x1_q : x2_q;
  assign xrMax  = (x1_q < x2_q) ? x2_q : x1_q;
  assign ytMin  = (y1_q < y2_q) ? y1_q : y2_q;
  assign ybMax  = (y1_q < y2_q) ? y2_q : y1_q;
  assign xlClip = (xlMin > X_MAX) ? X_MAX : xlMin;
  assign xrClip = (xrMax > X_MAX) ? X_MAX : xrMax;
  assign ytClip = (ytMin > Y_MAX) ? Y_MAX : ytMin;
  assign ybClip = (ybMax > Y_MAX) ? Y_MAX : ybMax;

  // 40 bytes per row = 32 + 8, so the row base is two shifted copies of y.
  assign ytWide      = {{(ADDR_W-8){1'b0}}, ytClip};
  assign rowBaseInit = (ytWide << 5) + (ytWide << 3);

  assign wrAddr  = rowBase_q + {{(ADDR_W-6){1'b0}}, col_q};
  assign inWrite = (state_q == WRITE);

  edge_mask_gen u_edge_mask_gen (
    .xl_i       (xlLo_q),
    .xr_i       (xrLo_q),
    .is_left_i  (col_q == bl_q),
    .is_right_i (col_q == br_q),
    .mask_o     (wrMask)
  );

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign fb_we_o   = inWrite;
  assign fb_addr_o = inWrite ? wrAddr : '0;
  assign fb_mask_o = inWrite ? wrMask : 8'h00;
  assign fb_data_o = {8{fill_q}};

  always_comb begin
    state_d   = state_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    fill_d    = fill_q;
    xlLo_d    = xlLo_q;
    xrLo_d    = xrLo_q;
    bl_d      = bl_q;
    br_d      = br_q;
    col_d     = col_q;
    yb_d      = yb_q;
    row_d     = row_q;
    rowBase_d = rowBase_q;
    case (state_q)
      IDLE: begin
        if (start_fill_i) begin
          x1_d    = x1_i;
          x2_d    = x2_i;
          y1_d    = y1_i;
          y2_d    = y2_i;
          fill_d  = fill_value_i;
          state_d = SETUP;
        end
      end
      SETUP: begin
        xlLo_d    = xlClip[2:0];
        xrLo_d    = xrClip[2:0];
        bl_d      = xlClip[8:3];
        br_d      = xrClip[8:3];
        col_d     = xlClip[8:3];
        row_d     = ytClip;
        yb_d      = ybClip;
        rowBase_d = rowBaseInit;
        state_d   = WRITE;
      end
      WRITE: begin
        if (fb_ready_i) begin
          if (col_q < br_q) begin
            col_d = col_q + 6'd1;
          end else if (row_q < yb_q) begin
            col_d     = bl_q;
            row_d     = row_q + 8'd1;
            rowBase_d = rowBase_q + ROW_STRIDE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      fill_q    <= 1'b0;
      xlLo_q    <= '0;
      xrLo_q    <= '0;
      bl_q      <= '0;
      br_q      <= '0;
      col_q     <= '0;
      yb_q      <= '0;
      row_q     <= '0;
      rowBase_q <= '0;
    end else begin
      state_q   <= state_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      fill_q    <= fill_d;
      xlLo_q    <= xlLo_d;
      xrLo_q    <= xrLo_d;
      bl_q      <= bl_d;
      br_q      <= br_d;
      col_q     <= col_d;
      yb_q      <= yb_d;
      row_q     <= row_d;
      rowBase_q <= rowBase_d;
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed vector table, multi-cycle
// corner sequences and random rectangles against a pixel-level reference model.
module tb_rect_fill_engine;
  import gfx_pkg::*;

  typedef struct {
    int addr;
    int mask;
    int data;
  } wr_t;

  typedef struct {
    int   x1, y1, x2, y2;
    logic v;
    int   expN, expFirstAddr, expFirstMask, expLastAddr, expLastMask, expData;
  } vec_t;

  logic              clk = 1'b0;
  logic              rstN;
  logic              startFill, fillValue, fbReady;
  x_t                x1, x2;
  y_t                y1, y2;
  logic              busy, done, fbWe;
  logic [ADDR_W-1:0] fbAddr;
  logic [7:0]        fbData, fbMask;

  wr_t  expQ[$];
  vec_t vecs[4];
  int   nChecks = 0;
  int   nFails  = 0;
  int   gAccepted, gFirstAddr, gFirstMask, gLastAddr, gLastMask, gData;

  always #5 clk = ~clk;

  rect_fill_engine dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .start_fill_i (startFill),
    .fill_value_i (fillValue),
    .x1_i         (x1),
    .y1_i         (y1),
    .x2_i         (x2),
    .y2_i         (y2),
    .busy_o       (busy),
    .done_o       (done),
    .fb_we_o      (fbWe),
    .fb_addr_o    (fbAddr),
    .fb_data_o    (fbData),
    .fb_mask_o    (fbMask),
    .fb_ready_i   (fbReady)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // Reference model: sorts and clips the corners, then decides each pixel of
  // every touched byte individually against the inclusive rectangle.
  task automatic buildExpected(input int ax1, input int ay1, input int ax2, input int ay2, input logic v);
    int xl, xr, yt, yb, m;
    expQ.delete();
    xl = (ax1 < ax2) ? ax1 : ax2;
    xr = (ax1 < ax2) ? ax2 : ax1;
    yt = (ay1 < ay2) ? ay1 : ay2;
    yb = (ay1 < ay2) ? ay2 : ay1;
    if (xl > H_RES - 1) xl = H_RES - 1;
    if (xr > H_RES - 1) xr = H_RES - 1;
    if (yt > V_RES - 1) yt = V_RES - 1;
    if (yb > V_RES - 1) yb = V_RES - 1;
    for (int y = yt; y <= yb; y++) begin
      for (int b = xl / 8; b <= xr / 8; b++) begin
        m = 0;
        for (int i = 0; i < 8; i++) begin
          if ((8 * b + i >= xl) && (8 * b + i <= xr)) m = m | (1 << i);
        end
        expQ.push_back('{addr: y * BYTES_PER_ROW + b, mask: m, data: v ? 255 : 0});
      end
    end
  endtask

  // readyMode: 0 = always ready, 1 = random ready, 2 = 5-cycle stall on the 3rd write.
  task automatic applyStimulus(input int ax1, input int ay1, input int ax2, input int ay2,
                               input logic v, input int readyMode, input bit midStart,
                               input bit doneStart, input string tag);
    int  n, doneCyc, firstWe, lastAcc, stallCnt, busyErr, extraErr, budget;
    wr_t e;
    buildExpected(ax1, ay1, ax2, ay2, v);
    n = expQ.size();
    doneCyc = -1; firstWe = -1; lastAcc = -1; stallCnt = 0; busyErr = 0; extraErr = 0;
    gAccepted = 0; gFirstAddr = -1; gFirstMask = -1; gLastAddr = -1; gLastMask = -1; gData = -1;
    budget = 3 * n + 100;
    @(posedge clk); #1;
    x1 = x_t'(ax1); y1 = y_t'(ay1); x2 = x_t'(ax2); y2 = y_t'(ay2);
    fillValue = v;
    startFill = 1'b1;
    fbReady = (readyMode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (cyc == 0) checkOutput({tag, " busy_cycle0"}, int'(busy), 0);
      if (cyc >= 1 && !busy) busyErr++;
      if (fbWe) begin
        if (firstWe < 0) firstWe = cyc;
        if (expQ.size() == 0) begin
          extraErr++;
        end else begin
          e = expQ[0];
          checkOutput({tag, " addr"}, int'(fbAddr), e.addr);
          checkOutput({tag, " mask"}, int'(fbMask), e.mask);
          checkOutput({tag, " data"}, int'(fbData), e.data);
          if (fbReady) begin
            if (gAccepted == 0) begin
              gFirstAddr = int'(fbAddr);
              gFirstMask = int'(fbMask);
            end
            gLastAddr = int'(fbAddr);
            gLastMask = int'(fbMask);
            gData     = int'(fbData);
            void'(expQ.pop_front());
            gAccepted++;
            lastAcc = cyc;
          end else begin
            stallCnt++;
          end
        end
      end
      if (done) begin
        doneCyc = cyc;
        break;
      end
      @(posedge clk); #1;
      startFill = 1'b0;
      if ((midStart && cyc + 1 == 5) || (doneStart && cyc + 1 == 2 + n)) begin
        x1 = 9'd0; y1 = 8'd0; x2 = 9'd319; y2 = 8'd199;
        fillValue = ~v;
        startFill = 1'b1;
      end
      case (readyMode)
        1:       fbReady = ($urandom_range(0, 3) != 0);
        2:       fbReady = !(gAccepted == 2 && stallCnt < 5);
        default: fbReady = 1'b1;
      endcase
    end
    @(posedge clk); #1;
    startFill = 1'b0;
    fbReady = 1'b1;
    @(negedge clk);
    checkOutput({tag, " first_we_cycle"}, firstWe, 2);
    checkOutput({tag, " done_cycle"}, doneCyc, (readyMode == 0) ? 2 + n : lastAcc + 1);
    checkOutput({tag, " write_count"}, gAccepted, n);
    checkOutput({tag, " missing_writes"}, expQ.size(), 0);
    checkOutput({tag, " extra_writes"}, extraErr, 0);
    checkOutput({tag, " busy_drop"}, busyErr, 0);
    checkOutput({tag, " idle_after_done"}, int'({busy, done, fbWe}), 0);
    if (readyMode == 2) checkOutput({tag, " stall_cycles"}, stallCnt, 5);
  endtask

  initial begin
    int seen, doneSeen, rx1, rx2, ry1, ry2;

    vecs[0] = '{x1: 0,   y1: 0,   x2: 0,   y2: 0,   v: 1'b1, expN: 1,   expFirstAddr: 0,    expFirstMask: 8'h01,
                expLastAddr: 0,    expLastMask: 8'h01, expData: 8'hFF};
    vecs[1] = '{x1: 20,  y1: 40,  x2: 100, y2: 100, v: 1'b1, expN: 671, expFirstAddr: 1602, expFirstMask: 8'hF0,
                expLastAddr: 4012, expLastMask: 8'h1F, expData: 8'hFF};
    vecs[2] = '{x1: 100, y1: 100, x2: 20,  y2: 40,  v: 1'b1, expN: 671, expFirstAddr: 1602, expFirstMask: 8'hF0,
                expLastAddr: 4012, expLastMask: 8'h1F, expData: 8'hFF};
    vecs[3] = '{x1: 300, y1: 190, x2: 511, y2: 255, v: 1'b0, expN: 30,  expFirstAddr: 7637, expFirstMask: 8'hF0,
                expLastAddr: 7999, expLastMask: 8'hFF, expData: 8'h00};

    rstN = 1'b0; startFill = 1'b0; fillValue = 1'b0; fbReady = 1'b1;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset we", int'(fbWe), 0);
    checkOutput("reset addr", int'(fbAddr), 0);
    checkOutput("reset data", int'(fbData), 0);
    checkOutput("reset mask", int'(fbMask), 0);
    @(posedge clk); #1;
    rstN = 1'b1;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2, vecs[i].v, 0, 1'b0, 1'b0,
                    $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d n", i), gAccepted, vecs[i].expN);
      checkOutput($sformatf("vec%0d first_addr", i), gFirstAddr, vecs[i].expFirstAddr);
      checkOutput($sformatf("vec%0d first_mask", i), gFirstMask, vecs[i].expFirstMask);
      checkOutput($sformatf("vec%0d last_addr", i), gLastAddr, vecs[i].expLastAddr);
      checkOutput($sformatf("vec%0d last_mask", i), gLastMask, vecs[i].expLastMask);
      checkOutput($sformatf("vec%0d data", i), gData, vecs[i].expData);
    end

    applyStimulus(20, 40, 30, 41, 1'b1, 2, 1'b0, 1'b0, "stall");
    applyStimulus(20, 40, 100, 50, 1'b1, 0, 1'b1, 1'b0, "mid_start");
    applyStimulus(5, 3, 13, 4, 1'b0, 0, 1'b0, 1'b1, "done_start");

    // Abort a large fill with reset while it is writing.
    @(posedge clk); #1;
    x1 = 9'd0; y1 = 8'd0; x2 = 9'd319; y2 = 8'd199; fillValue = 1'b1; startFill = 1'b1;
    @(posedge clk); #1;
    startFill = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (fbWe) seen = 1;
    end
    checkOutput("abort we_seen", seen, 1);
    repeat (3) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("abort we", int'(fbWe), 0);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort addr", int'(fbAddr), 0);
    checkOutput("abort data", int'(fbData), 0);
    doneSeen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) doneSeen = 1;
    end
    @(posedge clk); #1;
    rstN = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done || busy) doneSeen = 1;
    end
    checkOutput("abort no_done", doneSeen, 0);
    applyStimulus(8, 10, 23, 12, 1'b1, 0, 1'b0, 1'b0, "after_abort");

    for (int r = 0; r < 8; r++) begin
      rx1 = $urandom_range(0, 511);
      rx2 = $urandom_range(0, 511);
      ry1 = $urandom_range(0, 255);
      ry2 = ry1 + $urandom_range(0, 6);
      if (ry2 > 255) ry2 = 255;
      if (r[0]) begin
        applyStimulus(rx1, ry1, rx2, ry2, 1'($urandom_range(0, 1)), 1, 1'b0, 1'b0, $sformatf("rand%0d", r));
      end else begin
        applyStimulus(rx1, ry2, rx2, ry1, 1'($urandom_range(0, 1)), 1, 1'b0, 1'b0, $sformatf("rand%0d", r));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
